// File: rtl/jtframe_pll_phase_pkg.sv
// Shared types for the PLL phase-shift controller.
package jtframe_pll_pkg;

    typedef enum logic [2:0] {
        LOCKWAIT,
        IDLE,
        STEP,
        WAITLO,
        WAITHI,
        ERR
    } ph_state_e;

    localparam logic PH_UP = 1'b1;
    localparam logic PH_DN = 1'b0;

    // outclk_1 carries the shifted SDRAM clock on every supported family
    localparam logic [4:0] CNTSEL_CYCLONEV  = 5'd1;
    localparam logic [4:0] CNTSEL_CYCLONE10 = 5'd1;
    localparam logic [4:0] CNTSEL_DEF       = CNTSEL_CYCLONEV;

endpackage

// File: rtl/jtframe_pll_phase_if.sv
// Config/PLL-side signal bundle of jtframe_pll_phase.
interface jtframe_pll_phase_if #(
    parameter int PHW = 6
);
    logic           locked;
    logic [PHW-1:0] target;
    logic           go;
    logic           busy;
    logic [PHW-1:0] cur;
    logic           err;
    logic           rst_core;
    logic           pll_phase_en;
    logic           pll_updn;
    logic [4:0]     pll_cntsel;
    logic           pll_phase_done;

    modport master (
        output locked, target, go, pll_phase_done,
        input  busy, cur, err, rst_core,
        input  pll_phase_en, pll_updn, pll_cntsel
    );

    modport slave (
        input  locked, target, go, pll_phase_done,
        output busy, cur, err, rst_core,
        output pll_phase_en, pll_updn, pll_cntsel
    );
endinterface

// File: rtl/jtframe_sync.sv
// Two-flop synchronizer for single-bit asynchronous inputs.
module jtframe_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    logic [1:0] ff_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ff_q <= '0;
        else     ff_q <= {ff_q[0], d_i};
    end

    assign q_o = ff_q[1];
endmodule

// File: rtl/jtframe_pll_phase.sv
// Run-time SDRAM clock phase stepper with lock-gated core reset.
// JTFRAME_PHASE_RST_EN: also hold rst_core during and just after a move.
module jtframe_pll_phase
    import jtframe_pll_pkg::*;
#(
    parameter int         PHW     = 6,
    parameter logic [4:0] CNTSEL  = CNTSEL_DEF,
    parameter int         TOUT    = 255,
    parameter int         RSTHOLD = 1023
) (
    input logic clk,
    input logic rst,
    jtframe_pll_phase_if.slave io
);
    localparam int TW = $clog2(TOUT + 1);
    localparam int HW = $clog2(RSTHOLD + 1);

    ph_state_e      st_q, st_d;
    logic [PHW-1:0] cur_q, cur_d;
    logic [PHW-1:0] tgt_q, tgt_d;
    logic           updn_q, updn_d;
    logic [TW-1:0]  tcnt_q, tcnt_d;
    logic [HW-1:0]  hcnt_q, hcnt_d;
    logic [PHW-1:0] nxt;
    logic           lock_s, done_s, busy;

    jtframe_sync u_lock (
        .clk(clk), .rst(rst), .d_i(io.locked), .q_o(lock_s)
    );

    jtframe_sync u_done (
        .clk(clk), .rst(rst), .d_i(io.pll_phase_done), .q_o(done_s)
    );

    // Saturating step; a legal target never drives it into a rail
    always_comb begin
        nxt = cur_q;
        if (updn_q == PH_UP) begin
            if (cur_q != '1) nxt = cur_q + 1'b1;
        end else begin
            if (cur_q != '0) nxt = cur_q - 1'b1;
        end
    end

    always_comb begin
        st_d   = st_q;
        cur_d  = cur_q;
        tgt_d  = tgt_q;
        updn_d = updn_q;
        tcnt_d = tcnt_q;
        hcnt_d = hcnt_q;
        unique case (st_q)
            LOCKWAIT: begin
                if (!lock_s)                  hcnt_d = '0;
                else if (hcnt_q == HW'(RSTHOLD)) st_d = IDLE;
                else                          hcnt_d = hcnt_q + 1'b1;
            end
            IDLE: begin
                if (io.go) begin
                    tgt_d = io.target;
                    if (io.target != cur_q) begin
                        updn_d = (io.target > cur_q) ? PH_UP : PH_DN;
                        st_d   = STEP;
                    end
                end
            end
            STEP: st_d = WAITLO;
            WAITLO: begin
                if (!done_s)                   st_d = WAITHI;
                else if (tcnt_q == TW'(TOUT)) st_d = ERR;
                else                           tcnt_d = tcnt_q + 1'b1;
            end
            WAITHI: begin
                if (done_s) begin
                    cur_d = nxt;
                    st_d  = (nxt == tgt_q) ? IDLE : STEP;
                end else if (tcnt_q == TW'(TOUT)) begin
                    st_d = ERR;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            ERR: st_d = ERR;
            default: st_d = LOCKWAIT;
        endcase
        // Lock loss abandons any step in flight without counting it
        if (st_q != ERR && !lock_s) begin
            st_d   = LOCKWAIT;
            cur_d  = cur_q;
            hcnt_d = '0;
        end
        if (st_d != st_q) tcnt_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q   <= LOCKWAIT;
            cur_q  <= '0;
            tgt_q  <= '0;
            updn_q <= PH_DN;
            tcnt_q <= '0;
            hcnt_q <= '0;
        end else begin
            st_q   <= st_d;
            cur_q  <= cur_d;
            tgt_q  <= tgt_d;
            updn_q <= updn_d;
            tcnt_q <= tcnt_d;
            hcnt_q <= hcnt_d;
        end
    end

    assign busy = (st_q == STEP) || (st_q == WAITLO) || (st_q == WAITHI);

`ifdef JTFRAME_PHASE_RST_EN
    logic [4:0] pcnt_q, pcnt_d;

    always_comb begin
        pcnt_d = pcnt_q;
        if (pcnt_q != '0) pcnt_d = pcnt_q - 1'b1;
        if (st_q == WAITHI && st_d == IDLE) pcnt_d = 5'd16;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pcnt_q <= '0;
        else     pcnt_q <= pcnt_d;
    end

    assign io.rst_core = (st_q == LOCKWAIT) || (st_q == ERR)
                      || busy || (pcnt_q != '0);
`else
    assign io.rst_core = (st_q == LOCKWAIT) || (st_q == ERR);
`endif

    assign io.busy         = busy;
    assign io.cur          = cur_q;
    assign io.err          = (st_q == ERR);
    assign io.pll_phase_en = (st_q == STEP) || (st_q == WAITLO);
    assign io.pll_updn     = updn_q;
    assign io.pll_cntsel   = CNTSEL;
endmodule

// File: tb/tb_jtframe_pll_phase.sv
// Scoreboard bench for jtframe_pll_phase with a behavioural PLL phase port.
module tb_jtframe_pll_phase;
    localparam int PHW     = 6;
    localparam int TOUT    = 255;
    localparam int RSTHOLD = 1023;
    localparam int LOCKLAT = 2 + RSTHOLD + 1;

    typedef struct {
        int          pulses;
        int          ups;
        logic [5:0]  cur;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jtframe_pll_phase_if #(.PHW(PHW)) io ();

    jtframe_pll_phase #(
        .PHW(PHW), .CNTSEL(5'd1), .TOUT(TOUT), .RSTHOLD(RSTHOLD)
    ) dut (
        .clk(clk), .rst(rst), .io(io.slave)
    );

    int   checks = 0;
    int   errors = 0;
    int   pulses = 0;
    int   ups    = 0;
    int   ph     = 0;
    bit   dead   = 1'b0;
    bit   en_prev = 1'b0;
    bit   busy_prev = 1'b0;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // PLL model: done drops after enable, returns two cycles later
    always @(negedge clk) begin
        if (!dead) begin
            case (ph)
                0: if (io.pll_phase_en) begin
                       io.pll_phase_done = 1'b0;
                       ph = 1;
                   end
                1: ph = 2;
                2: begin
                       io.pll_phase_done = 1'b1;
                       ph = 3;
                   end
                default: if (!io.pll_phase_en) ph = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (io.pll_phase_en && !en_prev) begin
            pulses++;
            if (io.pll_updn) ups++;
        end
        en_prev = io.pll_phase_en;
        if (busy_prev && !io.busy && sb.size() > 0) begin
            e = sb.pop_front();
            chk("pulses", pulses, e.pulses);
            chk("up_pulses", ups, e.ups);
            chk("cur_end", io.cur, e.cur);
        end
        busy_prev = io.busy;
    end

    task automatic wait_unlock(input string tag);
        int n;
        n = 0;
        for (int i = 1; i <= LOCKLAT + 50; i++) begin
            @(posedge clk);
            #1;
            if (!io.rst_core) begin
                n = i;
                break;
            end
        end
        chk(tag, n, LOCKLAT);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (!io.busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk("busy_timeout", ok, 1);
        @(negedge clk);
    endtask

    task automatic do_move(input logic [5:0] t, input int np,
                           input int nu, input logic [5:0] ec,
                           input bit regress);
        exp_t e;
        e.pulses = np;
        e.ups    = nu;
        e.cur    = ec;
        pulses = 0;
        ups    = 0;
        sb.push_back(e);
        @(negedge clk);
        io.target = t;
        io.go     = 1'b1;
        @(posedge clk);
        #1;
        io.go = 1'b0;
        chk("busy_n1", io.busy, 1);
        chk("en_n1", io.pll_phase_en, 1);
`ifdef JTFRAME_PHASE_RST_EN
        chk("rst_core_move", io.rst_core, 1);
`else
        chk("rst_core_move", io.rst_core, 0);
`endif
        if (regress) begin
            for (int i = 0; i < 100 && pulses < 2; i++) @(negedge clk);
            io.target = 6'd20;
            io.go     = 1'b1;
            @(negedge clk);
            io.go = 1'b0;
        end
        wait_idle();
    endtask

    initial begin
        int enc;
        bit saw_busy;
        io.locked         = 1'b1;
        io.target         = '0;
        io.go             = 1'b0;
        io.pll_phase_done = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", io.busy, 0);
        chk("rst_cur", io.cur, 0);
        chk("rst_err", io.err, 0);
        chk("rst_core", io.rst_core, 1);
        chk("rst_en", io.pll_phase_en, 0);
        chk("rst_updn", io.pll_updn, 0);
        chk("cntsel", io.pll_cntsel, 1);
        rst = 1'b0;
        wait_unlock("lock_release");
        chk("idle_busy", io.busy, 0);
        chk("idle_cur", io.cur, 0);

        do_move(6'd5, 5, 5, 6'd5, 1'b0);
        do_move(6'd2, 3, 0, 6'd2, 1'b1);

        pulses   = 0;
        saw_busy = 1'b0;
        @(negedge clk);
        io.target = 6'd2;
        io.go     = 1'b1;
        @(negedge clk);
        io.go = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (io.busy) saw_busy = 1'b1;
        end
        chk("noop_busy", saw_busy, 0);
        chk("noop_pulses", pulses, 0);
        chk("noop_cur", io.cur, 2);

        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_unlock("lock_rst2");
        chk("cur_after_rst", io.cur, 0);

        pulses = 0;
        @(negedge clk);
        io.target = 6'd10;
        io.go     = 1'b1;
        @(negedge clk);
        io.go = 1'b0;
        for (int i = 0; i < 200 && pulses < 2; i++) @(negedge clk);
        for (int i = 0; i < 50 && io.pll_phase_en; i++) @(negedge clk);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (io.pll_phase_en) break;
        end
        io.locked = 1'b0;
        repeat (5) @(negedge clk);
        chk("drop_pulses", pulses, 3);
        chk("drop_cur", io.cur, 2);
        chk("drop_rst_core", io.rst_core, 1);
        chk("drop_busy", io.busy, 0);
        chk("drop_en", io.pll_phase_en, 0);
        io.pll_phase_done = 1'b1;
        ph = 0;
        io.locked = 1'b1;
        wait_unlock("relock");
        chk("relock_cur", io.cur, 2);
        do_move(6'd4, 2, 2, 6'd4, 1'b0);

        dead = 1'b1;
        io.pll_phase_done = 1'b1;
        enc = 0;
        @(negedge clk);
        io.target = 6'd6;
        io.go     = 1'b1;
        @(posedge clk);
        #1;
        io.go = 1'b0;
        for (int i = 0; i < 2 * TOUT; i++) begin
            if (io.err) break;
            if (io.pll_phase_en) enc++;
            @(posedge clk);
            #1;
        end
        chk("tout_en_cycles", enc, TOUT + 2);
        chk("tout_err", io.err, 1);
        chk("tout_rst_core", io.rst_core, 1);
        chk("tout_cur", io.cur, 4);
        chk("tout_en", io.pll_phase_en, 0);
        chk("tout_busy", io.busy, 0);
        repeat (5) @(negedge clk);
        chk("err_sticky", io.err, 1);
        chk("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
